// File: rtl/umi_remap_cfg.sv
// umi_remap_cfg: UMI register slave holding a row/col remap table and an
// address window. Writes land in shadow registers; a commit write copies
// every shadow register to the active outputs in one cycle.
module umi_remap_cfg #(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 128,
  parameter int IDW   = 16,
  parameter int NMAPS = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 udev_req_valid,
  input  logic [CW-1:0]        udev_req_cmd,
  input  logic [AW-1:0]        udev_req_dstaddr,
  input  logic [AW-1:0]        udev_req_srcaddr,
  input  logic [DW-1:0]        udev_req_data,
  output logic                 udev_req_ready,
  output logic                 udev_resp_valid,
  output logic [CW-1:0]        udev_resp_cmd,
  output logic [AW-1:0]        udev_resp_dstaddr,
  output logic [AW-1:0]        udev_resp_srcaddr,
  output logic [DW-1:0]        udev_resp_data,
  input  logic                 udev_resp_ready,
  output logic [IDW*NMAPS-1:0] old_row_col_address,
  output logic [IDW*NMAPS-1:0] new_row_col_address,
  output logic [AW-1:0]        set_dstaddress_offset,
  output logic [AW-1:0]        set_dstaddress_high,
  output logic [AW-1:0]        set_dstaddress_low,
  output logic                 remap_update,
  output logic                 cfg_err
);

  localparam logic [4:0] OP_READ   = 5'h01;
  localparam logic [4:0] OP_WRITE  = 5'h03;
  localparam logic [4:0] OP_POSTED = 5'h05;
  localparam logic [4:0] OP_RRESP  = 5'h02;
  localparam logic [4:0] OP_WRESP  = 5'h04;

  typedef enum logic {IDLE, RESP} state_t;

  state_t          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [CW-1:0]   resp_cmd_q, resp_cmd_d;
  logic [AW-1:0]   resp_dst_q, resp_dst_d;
  logic [AW-1:0]   resp_src_q, resp_src_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;

  logic [IDW-1:0]  old_sh_q [NMAPS];
  logic [IDW-1:0]  old_sh_d [NMAPS];
  logic [IDW-1:0]  new_sh_q [NMAPS];
  logic [IDW-1:0]  new_sh_d [NMAPS];
  logic [IDW-1:0]  old_act_q [NMAPS];
  logic [IDW-1:0]  old_act_d [NMAPS];
  logic [IDW-1:0]  new_act_q [NMAPS];
  logic [IDW-1:0]  new_act_d [NMAPS];
  // window registers: 0 = offset, 1 = high, 2 = low
  logic [63:0]     win_sh_q [3];
  logic [63:0]     win_sh_d [3];
  logic [63:0]     win_act_q [3];
  logic [63:0]     win_act_d [3];
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic            upd_q, upd_d;

  logic [4:0]      opcode;
  logic [2:0]      size;
  logic [7:0]      len;
  logic [7:0]      off;
  logic [31:0]     wdata;
  logic            accept, known_op, fmt_ok, req_bad, do_rd, do_wr;
  logic [2:0]      old_idx, new_idx;
  logic [1:0]      win_idx;
  logic            old_hit, new_hit, win_hit;
  logic [31:0]     rdata;
  logic            unused_data;

  assign opcode = udev_req_cmd[4:0];
  assign size   = udev_req_cmd[7:5];
  assign len    = udev_req_cmd[15:8];
  assign off    = udev_req_dstaddr[7:0];
  assign wdata  = udev_req_data[31:0];
  assign unused_data = ^udev_req_data[DW-1:32];

  assign accept   = udev_req_valid && req_ready_q;
  assign known_op = (opcode == OP_READ) || (opcode == OP_WRITE) || (opcode == OP_POSTED);
  assign fmt_ok   = (size == 3'd2) && (len == 8'd0) && (off[1:0] == 2'b00);
  assign req_bad  = accept && !(known_op && fmt_ok);
  assign do_rd    = accept && fmt_ok && (opcode == OP_READ);
  assign do_wr    = accept && fmt_ok && ((opcode == OP_WRITE) || (opcode == OP_POSTED));

  assign old_idx = 3'((off - 8'h10) >> 2);
  assign new_idx = 3'((off - 8'h30) >> 2);
  assign win_idx = 2'((off - 8'h50) >> 3);
  assign old_hit = (off >= 8'h10) && (off < 8'h30) && (32'(old_idx) < NMAPS);
  assign new_hit = (off >= 8'h30) && (off < 8'h50) && (32'(new_idx) < NMAPS);
  assign win_hit = (off >= 8'h50) && (off < 8'h68);

  // register read mux: shadow values, zero-extended; unmapped reads 0
  always_comb begin
    rdata = 32'h0;
    if (off == 8'h04) begin
      rdata = {30'h0, pend_q, err_q};
    end else if (old_hit) begin
      rdata = 32'(old_sh_q[old_idx]);
    end else if (new_hit) begin
      rdata = 32'(new_sh_q[new_idx]);
    end else if (win_hit) begin
      rdata = off[2] ? win_sh_q[win_idx][63:32] : win_sh_q[win_idx][31:0];
    end
  end

  // register file next state: shadow writes, commit copy, sticky error
  always_comb begin
    old_sh_d  = old_sh_q;
    new_sh_d  = new_sh_q;
    old_act_d = old_act_q;
    new_act_d = new_act_q;
    win_sh_d  = win_sh_q;
    win_act_d = win_act_q;
    pend_d    = pend_q;
    err_d     = err_q;
    upd_d     = 1'b0;
    if (do_wr) begin
      if (off == 8'h00) begin
        if (wdata[0]) begin
          old_act_d = old_sh_q;
          new_act_d = new_sh_q;
          win_act_d = win_sh_q;
          upd_d     = 1'b1;
          pend_d    = 1'b0;
        end
      end else if (off == 8'h04) begin
        if (wdata[0]) err_d = 1'b0;
      end else if (old_hit) begin
        old_sh_d[old_idx] = wdata[IDW-1:0];
        pend_d            = 1'b1;
      end else if (new_hit) begin
        new_sh_d[new_idx] = wdata[IDW-1:0];
        pend_d            = 1'b1;
      end else if (win_hit) begin
        if (off[2]) win_sh_d[win_idx][63:32] = wdata;
        else        win_sh_d[win_idx][31:0]  = wdata;
        pend_d = 1'b1;
      end
    end
    // a new error wins over a same-cycle clear
    if (req_bad) err_d = 1'b1;
  end

  // request/response FSM next state and registered response fields
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_cmd_d   = resp_cmd_q;
    resp_dst_d   = resp_dst_q;
    resp_src_d   = resp_src_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      IDLE: begin
        if (accept && ((opcode == OP_READ) || (opcode == OP_WRITE))) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_cmd_d   = {udev_req_cmd[CW-1:5], (opcode == OP_READ) ? OP_RRESP : OP_WRESP};
          resp_dst_d   = udev_req_srcaddr;
          resp_src_d   = udev_req_dstaddr;
          resp_data_d  = {{(DW-32){1'b0}}, do_rd ? rdata : 32'h0};
        end
      end
      RESP: begin
        if (udev_resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // FSM and response registers
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_cmd_q   <= '0;
      resp_dst_q   <= '0;
      resp_src_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_cmd_q   <= resp_cmd_d;
      resp_dst_q   <= resp_dst_d;
      resp_src_q   <= resp_src_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // shadow/active registers; reset to identity map and zero window
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < NMAPS; i++) begin
        old_sh_q[i]  <= IDW'(i);
        new_sh_q[i]  <= IDW'(i);
        old_act_q[i] <= IDW'(i);
        new_act_q[i] <= IDW'(i);
      end
      for (int k = 0; k < 3; k++) begin
        win_sh_q[k]  <= 64'h0;
        win_act_q[k] <= 64'h0;
      end
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      old_sh_q  <= old_sh_d;
      new_sh_q  <= new_sh_d;
      old_act_q <= old_act_d;
      new_act_q <= new_act_d;
      win_sh_q  <= win_sh_d;
      win_act_q <= win_act_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NMAPS; gi++) begin : g_tbl
      assign old_row_col_address[gi*IDW +: IDW] = old_act_q[gi];
      assign new_row_col_address[gi*IDW +: IDW] = new_act_q[gi];
    end
  endgenerate

  assign set_dstaddress_offset = win_act_q[0][AW-1:0];
  assign set_dstaddress_high   = win_act_q[1][AW-1:0];
  assign set_dstaddress_low    = win_act_q[2][AW-1:0];

  assign udev_req_ready    = req_ready_q;
  assign udev_resp_valid   = resp_valid_q;
  assign udev_resp_cmd     = resp_cmd_q;
  assign udev_resp_dstaddr = resp_dst_q;
  assign udev_resp_srcaddr = resp_src_q;
  assign udev_resp_data    = resp_data_q;
  assign remap_update      = upd_q;
  assign cfg_err           = err_q;

endmodule

// File: doc/umi_remap_cfg.md
UMI_REMAP_CFG -- requirements
Module: umi_remap_cfg

Interface
REQ-001 Parameters SHALL be: CW 32 (UMI command width); AW 64 (address width); DW 128 (data width); IDW 16 (row/col id width); NMAPS 8 (remap table entries, 1..8).
REQ-002 Ports SHALL be: clk  in  1  single clock; nreset  in  1  synchronous active-low reset.
REQ-003 Ports SHALL be: udev_req_valid/cmd/dstaddr/srcaddr/data  in  1/CW/AW/AW/DW  config request; udev_req_ready  out  1.
REQ-004 Ports SHALL be: udev_resp_valid/cmd/dstaddr/srcaddr/data  out  1/CW/AW/AW/DW  config response; udev_resp_ready  in  1.
REQ-005 Ports SHALL be: old_row_col_address, new_row_col_address  out  IDW*NMAPS  active remap table; set_dstaddress_offset/high/low  out  AW each  active window regs; remap_update  out  1  one-cycle commit pulse; cfg_err  out  1  sticky error.

Function
REQ-006 Opcode SHALL be cmd[4:0]: 0x01 READ, 0x03 WRITE, 0x05 POSTED; size cmd[7:5], len cmd[15:8]; register offset = dstaddr[7:0].
REQ-007 Register map (32-bit, word-aligned) SHALL be: 0x00 CTRL (W bit0=commit); 0x04 STATUS (R bit0 cfg_err, bit1 pending-commit, W1C bit0); 0x10+4i OLD[i]; 0x30+4i NEW[i]; 0x50/0x54 offset lo/hi; 0x58/0x5C high lo/hi; 0x60/0x64 low lo/hi.
REQ-008 Writes SHALL update shadow registers only; active outputs SHALL change only on commit.
REQ-009 A commit write SHALL copy all shadow registers to active outputs on the next clk edge and assert remap_update for exactly that one cycle; pending-commit SHALL set on any shadow write and clear on commit.
REQ-010 OLD/NEW writes SHALL take data[IDW-1:0]; reads SHALL zero-extend to 32 bits and return shadow values; unmapped offsets read 0 and writes to them are ignored.
REQ-011 FSM SHALL have states IDLE and RESP; udev_req_ready SHALL be 1 only in IDLE.
REQ-012 In IDLE, an accepted READ or WRITE SHALL move to RESP with response registered next cycle; POSTED SHALL perform the write, send no response and stay in IDLE.
REQ-013 Response SHALL carry opcode 0x02 (READ resp) or 0x04 (WRITE resp), cmd[CW-1:5] copied from request, dstaddr = request srcaddr, srcaddr = request dstaddr, data[31:0] = read value (0 for writes), upper data 0.
REQ-014 In RESP, all udev_resp_* outputs SHALL hold stable until udev_resp_ready=1, then return to IDLE; new request acceptable the following cycle (throughput one request per 2 cycles minimum).
REQ-015 Request with size != 2, len != 0, misaligned dstaddr[1:0], or any other opcode SHALL be consumed, set cfg_err, perform no register access; READ/WRITE still get a response with data 0.
REQ-016 Commit and shadow write in same request are impossible (single beat); a STATUS W1C and a new error in same cycle SHALL leave cfg_err set.
REQ-017 Index i >= NMAPS in OLD/NEW range SHALL be treated as unmapped.

Reset
REQ-018 On nreset=0 at clk edge: FSM=IDLE, udev_resp_valid=0, udev_req_ready=0 during reset, remap_update=0, cfg_err=0, pending-commit=0.
REQ-019 On reset, shadow and active OLD[i]=i, NEW[i]=i (identity map), window regs = 0.
REQ-020 Reset during RESP SHALL drop the pending response without a handshake.

Verification
REQ-021 WRITE 0x30 data 0xABCD -> WRITE resp, dstaddr=req srcaddr; new_row_col_address[15:0] stays 0x0000 until commit.
REQ-022 POSTED 0x00 data 1 after REQ-021 -> no response; next cycle new_row_col_address[15:0]=0xABCD, remap_update high exactly 1 cycle, STATUS bit1=0.
REQ-023 READ 0x10+4*3 after reset -> READ resp data[31:0]=0x3.
REQ-024 READ with udev_resp_ready held 0 for 10 cycles -> resp held stable, udev_req_ready=0 throughout; completes on ready.
REQ-025 WRITE size=3 -> WRITE resp, no register change, cfg_err=1; WRITE 0x04 data 1 -> cfg_err=0.
REQ-026 nreset asserted while resp pending -> next cycle udev_resp_valid=0, table back to identity.
